// File: rtl/u8_pack_pkg.sv
// Shared types for the byte-to-word packer: lane geometry, the FIFO entry
// layout and the lane-enable helper.
package u8_pack_pkg;

  localparam int LANES      = 4;
  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [LANES-1:0]      keep_t;

  typedef struct packed {
    word_t word;
    keep_t keep;
    logic  last;
  } pack_entry_t;

  // Lanes 0..cnt are populated when a word closes with the byte in lane cnt.
  function automatic keep_t keep_mask(input logic [1:0] cnt);
    keep_t m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (i <= int'(cnt));
    end
    return m;
  endfunction

endpackage

// File: rtl/u8_pack_fifo.sv
// Show-ahead synchronous FIFO of packed entries. Occupancy is tracked in a
// level counter so full/empty never depend on pointer comparison.
module u8_pack_fifo
  import u8_pack_pkg::*;
#(
  parameter  int DEPTH       = 4,
  localparam int LEVEL_WIDTH = $clog2(DEPTH + 1),
  localparam int PTR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  pack_entry_t            din_i,
  output pack_entry_t            dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [LEVEL_WIDTH-1:0] level_o
);

  pack_entry_t            mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_reg;
  logic [PTR_WIDTH-1:0]   rd_ptr_reg;
  logic [LEVEL_WIDTH-1:0] level_reg;
  logic                   do_push;
  logic                   do_pop;

  assign empty_o = (level_reg == '0);
  assign full_o  = (level_reg == LEVEL_WIDTH'(DEPTH));
  assign level_o = level_reg;

  // A full FIFO still takes a word when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LEVEL_WIDTH'(1);
        2'b01:   level_reg <= level_reg - LEVEL_WIDTH'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din_i;
    end
  end

  // Head is gated by occupancy so reset clears the visible outputs at once.
  assign dout_o = empty_o ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/u8_word_packer.sv
// Packs a no-backpressure byte stream into little-endian 32-bit words, closes
// partial words on end-of-line, and flags words lost to a full FIFO.
module u8_word_packer
  import u8_pack_pkg::*;
#(
  parameter  int DEPTH       = 4,
  localparam int LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [7:0]             u8_i,
  input  logic                   valid_i,
  input  logic                   last_i,
  output logic [31:0]            word_o,
  output logic [3:0]             keep_o,
  output logic                   last_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   overflow_o,
  output logic [LEVEL_WIDTH-1:0] level_o
);

  logic [1:0]  cnt_reg;
  word_t       staging_reg;
  word_t       merged;
  logic        overflow_reg;
  logic        commit;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  pack_entry_t commit_entry;
  pack_entry_t head;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign merged[8*gi +: 8] = (valid_i && cnt_reg == 2'(gi)) ? u8_i
                                                                 : staging_reg[8*gi +: 8];
    end
  endgenerate

  assign commit       = valid_i && ((cnt_reg == 2'd3) || last_i);
  assign commit_entry = '{word: merged, keep: keep_mask(cnt_reg), last: last_i};
  assign pop          = valid_o && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg      <= '0;
      staging_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (valid_i) begin
        if (commit) begin
          cnt_reg     <= '0;
          staging_reg <= '0;
        end else begin
          cnt_reg     <= cnt_reg + 2'd1;
          staging_reg <= merged;
        end
      end
      // The lane counter restarts even when the word itself is dropped.
      if (commit && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  u8_pack_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (commit),
    .pop_i   (pop),
    .din_i   (commit_entry),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign valid_o    = !fifo_empty;
  assign word_o     = head.word;
  assign keep_o     = head.keep;
  assign last_o     = head.last;
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_u8_word_packer.sv
// Bench for u8_word_packer: queue-based model compared every cycle, plus
// directed scenarios with literal expectations and a randomized soak.
module tb_u8_word_packer;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [7:0]    u8_i;
  logic          valid_i;
  logic          last_i;
  logic          ready_i;
  logic [31:0]   word_o;
  logic [3:0]    keep_o;
  logic          last_o;
  logic          valid_o;
  logic          overflow_o;
  logic [LW-1:0] level_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  u8_word_packer #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .u8_i       (u8_i),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .word_o     (word_o),
    .keep_o     (keep_o),
    .last_o     (last_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .overflow_o (overflow_o),
    .level_o    (level_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  k;
    logic        l;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] mb[$];
  bit         m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: bytes gather in a list; a line end or four bytes close a word,
  // which enters a bounded queue unless it is full and nothing leaves.
  always @(posedge clk_i or negedge rst_ni) begin
    ent_t e;
    bit   pop;
    if (!rst_ni) begin
      mq.delete();
      mb.delete();
      m_ovf = 1'b0;
    end else begin
      pop = (mq.size() > 0) && ready_i;
      if (pop) void'(mq.pop_front());
      if (valid_i) begin
        mb.push_back(u8_i);
        if (mb.size() == 4 || last_i) begin
          e.w = 32'h0;
          for (int i = 0; i < mb.size(); i++) e.w = e.w | (32'(mb[i]) << (8 * i));
          e.k = 4'((1 << mb.size()) - 1);
          e.l = last_i;
          if (mq.size() < DEPTH) mq.push_back(e);
          else m_ovf = 1'b1;
          mb.delete();
        end
      end
    end
  end

  always @(negedge clk_i) begin
    chk("valid", 32'(valid_o), 32'(mq.size() > 0));
    chk("level", 32'(level_o), 32'(mq.size()));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    if (mq.size() > 0) begin
      chk("word", word_o, mq[0].w);
      chk("keep", 32'(keep_o), 32'(mq[0].k));
      chk("last", 32'(last_o), 32'(mq[0].l));
    end
  end

  task automatic drive(input logic v, input logic [7:0] b, input logic l, input logic r);
    valid_i = v;
    u8_i    = b;
    last_i  = l;
    ready_i = r;
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] w, input logic [3:0] k,
                          input logic l);
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_word"}, word_o, w);
    chk({tag, "_keep"}, 32'(keep_o), 32'(k));
    chk({tag, "_last"}, 32'(last_o), 32'(l));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_level"}, 32'(level_o), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow_o), 32'd0);
    chk({tag, "_word"}, word_o, 32'd0);
    chk({tag, "_keep"}, 32'(keep_o), 32'd0);
    chk({tag, "_last"}, 32'(last_o), 32'd0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    rst_ni = 1'b0;
    #1;
    chk_zero(tag);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    chk_zero("reset");
    step();
    step();
    #1 rst_ni = 1'b1;
    step();

    // Full word, consumer ready.
    drive(1'b1, 8'h11, 1'b0, 1'b1); step();
    drive(1'b1, 8'h22, 1'b0, 1'b1); step();
    drive(1'b1, 8'h33, 1'b0, 1'b1); step();
    drive(1'b1, 8'h44, 1'b0, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk_head("full_word", 32'h44332211, 4'hF, 1'b0);
    step();

    // Partial word on end-of-line, then a fresh line starting in lane 0.
    drive(1'b1, 8'hAA, 1'b0, 1'b1); step();
    drive(1'b1, 8'hBB, 1'b1, 1'b1); step();
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    chk_head("eol2", 32'h0000BBAA, 4'h3, 1'b1);
    step();
    drive(1'b1, 8'hCC, 1'b1, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk_head("lane0", 32'h000000CC, 4'h1, 1'b1);
    step();

    // Single-byte line.
    drive(1'b1, 8'h7F, 1'b1, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk_head("single", 32'h0000007F, 4'h1, 1'b1);
    step();

    // Overflow: 20 bytes, no consumer.
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_level", 32'(level_o), 32'd4);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk_head("drain0", 32'h04030201, 4'hF, 1'b0); step();
    chk_head("drain1", 32'h08070605, 4'hF, 1'b0); step();
    chk_head("drain2", 32'h0C0B0A09, 4'hF, 1'b0); step();
    chk_head("drain3", 32'h100F0E0D, 4'hF, 1'b0); step();
    chk("drain_empty", 32'(valid_o), 32'd0);
    chk("drain_ovf_sticky", 32'(overflow_o), 32'd1);

    // Push and pop on the same edge while full.
    pulse_reset("reset2");
    step();
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      step();
    end
    chk("full_level", 32'(level_o), 32'd4);
    drive(1'b1, 8'h54, 1'b0, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pp_level", 32'(level_o), 32'd4);
    chk("pp_ovf", 32'(overflow_o), 32'd0);
    chk_head("pp_head", 32'h37363534, 4'hF, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (5) step();

    // Asynchronous reset mid-stream: 3 buffered words plus 2 staged bytes.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_reset_level", 32'(level_o), 32'd3);
    pulse_reset("midreset");
    drive(1'b1, 8'hA1, 1'b0, 1'b1); step();
    drive(1'b1, 8'hA2, 1'b0, 1'b1); step();
    drive(1'b1, 8'hA3, 1'b0, 1'b1); step();
    drive(1'b1, 8'hA4, 1'b0, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk_head("post_reset", 32'hA4A3A2A1, 4'hF, 1'b0);
    step();

    // Randomized soak against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < (i < 1500 ? 5 : 2));
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (6) step();
    chk("final_empty", 32'(valid_o), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/u8_word_packer.md
# u8_word_packer

Packs the unsigned 8-bit sample stream produced by the fp16-to-u8 conversion stage into 32-bit little-endian words and buffers them in a small show-ahead FIFO for a valid/ready consumer such as a memory writer or streaming bus. The upstream converter has no backpressure. This block therefore absorbs bursts, reports loss through a sticky overflow flag, and closes partial words on end-of-line.

## Interface
- `DEPTH`, 4: FIFO depth in words; power of two, ≥ 2.
- `LEVEL_WIDTH`, `$clog2(DEPTH+1)`: width of `level_o`; local, not overridden.

- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_ni` input 1: reset, asynchronous and active-low; deassertion is synchronised externally.
- `u8_i` input 8: sample from the converter.
- `valid_i` input 1: `u8_i` is valid this cycle; no ready is returned.
- `last_i` input 1: end-of-line marker, qualified by `valid_i`.
- `word_o` output 32: packed word; byte k sits in bits [8k+7:8k].
- `keep_o` output 4: byte-lane enables for `word_o`.
- `last_o` output 1: this word ends a line.
- `valid_o` output 1: FIFO head is valid.
- `ready_i` input 1: consumer accepts the head word.
- `overflow_o` output 1: sticky; at least one word was dropped.
- `level_o` output `LEVEL_WIDTH`: current FIFO occupancy, 0..DEPTH.

## Operation
- **Lane counter.** `cnt` is 2 bits, reset value 0. A `staging` register (32 bits, zero-initialised) collects the bytes.
- **Accepted byte.** On every cycle with `valid_i`=1, `u8_i` is written into lane `cnt`.
- **Commit.** A word is committed when `valid_i` is high and either `cnt`==3 or `last_i`=1.
  - The committed entry is {`staging` with the current byte merged, `keep` = (2^(cnt+1))−1, `last_i`}.
  - `cnt` and `staging` return to 0.
  - Unused lanes are always zero.
- **No commit.** Otherwise, when `valid_i`=1 and no commit occurs, `cnt` increments.
- **Pop.** A pop occurs when `valid_o`&&`ready_i`.
- **Push.** A push is allowed when `level` < DEPTH, or when a pop happens in the same cycle.
  - When full with no pop, the committed word is discarded and `overflow_o` is set.
  - The lane counter still resets, so the next byte starts a fresh word.
- **Overflow flag.** `overflow_o` clears only on reset.
- **Occupancy.** Push and pop in the same cycle leave `level_o` unchanged.
- **Head outputs.** The FIFO is show-ahead. `word_o`, `keep_o` and `last_o` reflect the head entry whenever `valid_o`=1; they are don't-care otherwise.
- **Handshake.** Once `valid_o` is high, the head must stay stable until it is popped; the consumer may hold `ready_i` low indefinitely.
- **`last_i` with `valid_i`=0** is ignored.

## Timing
- **Reset.** Asserting `rst_ni` low immediately forces all of the following, regardless of the clock:
  - `valid_o`=0, `overflow_o`=0, `level_o`=0
  - `word_o`=0, `keep_o`=0, `last_o`=0
  - `cnt`=0; the staging word is discarded.
- **Reset mid-operation** loses any buffered and partial data; no partial word is emitted.
- **Latency.** A word committed on the edge at the end of cycle N is visible with `valid_o`=1 in cycle N+1, when the FIFO was empty.
- **Throughput.** One word per cycle out. The input sustains one byte per cycle indefinitely, provided the consumer pops at ≥ 1/4 rate, or at 1 word per line-end for short lines.
- **Pointer arithmetic.**
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally.
  - Full/empty is derived from `level`, not from pointer equality.
- **`level_o`** is registered and updates on the same edge as the push or pop.

## Structure
- **Package `u8_pack_pkg`.**
  - Constants: `LANES`=4 and `WORD_WIDTH`=32.
  - Typedefs: `word_t` [31:0] and `keep_t` [3:0].
  - Packed struct `pack_entry_t` {`word_t` word; `keep_t` keep; logic last}.
- **Sub-module `u8_pack_fifo`.** A generic show-ahead synchronous FIFO of `pack_entry_t`. It has:
  - ports: push, pop, full, empty, level;
  - async active-low reset.
- **Top level** holds only the lane counter, staging register and overflow flag.

## Test plan
- **Full words, consumer ready.** `ready_i`=1; bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `last_i`=0 → one word 0x44332211 with `keep_o`=0xF and `last_o`=0, visible one cycle after the 0x44 byte.
- **Partial word on end-of-line.** Bytes 0xAA, 0xBB with `last_i`=1 on 0xBB → `word_o`=0x0000BBAA, `keep_o`=0x3, `last_o`=1. A following byte 0xCC starts lane 0.
- **Overflow.** `ready_i`=0, DEPTH=4; 20 bytes 0x01..0x14 → `level_o` saturates at 4 and `overflow_o`=1. Releasing `ready_i` then yields exactly four words: 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D.
- **Push and pop while full.** FIFO full; commit a word in the same cycle that `ready_i`=1 → no drop, `overflow_o` stays 0, `level_o` stays 4.
- **Single-byte line.** `last_i`=1 with only byte 0x7F → `keep_o`=0x1 and `word_o`=0x0000007F.
- **Asynchronous reset mid-stream.** Assert `rst_ni` low between clock edges after 2 bytes and 3 buffered words → all outputs 0 immediately. After release, the next 4 bytes form a clean word with `keep_o`=0xF.
